// File: rtl/cpu_fpu_arbiter.sv
// Round-robin arbiter sharing one FPU between NREQ requesters over a level-held request/ready handshake.
// Optional FPU wait timeout is compiled in with `define CPU_FPU_ARB_TIMEOUT_EN.
module cpu_fpu_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [NREQ-1:0]      i_req_request,
  input  logic [5*NREQ-1:0]    i_req_op,
  input  logic [32*NREQ-1:0]   i_req_op1,
  input  logic [32*NREQ-1:0]   i_req_op2,
  input  logic [32*NREQ-1:0]   i_req_op3,
  output logic [NREQ-1:0]      o_req_ready,
  output logic [31:0]          o_req_result,
  output logic                 o_fpu_request,
  output logic [4:0]           o_fpu_op,
  output logic [31:0]          o_fpu_op1,
  output logic [31:0]          o_fpu_op2,
  output logic [31:0]          o_fpu_op3,
  input  logic                 i_fpu_ready,
  input  logic [31:0]          i_fpu_result,
  output logic                 o_busy,
  output logic                 o_timeout
);

  localparam int GW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 4 || TIMEOUT < 1) begin : g_param_check
    $error("cpu_fpu_arbiter: NREQ must be 2..4 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   ptr_q, ptr_d;
  logic [4:0]      op_q, op_d;
  logic [31:0]     op1_q, op1_d, op2_q, op2_d, op3_q, op3_d;
  logic [31:0]     result_q, result_d;
  logic            found;
  logic [GW-1:0]   pick;

`ifdef CPU_FPU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]   wait_q, wait_d;
  logic            timeout_q, timeout_d;
`endif

  // First requesting index after the pointer, wrapping modulo NREQ.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    found = 1'b0;
    pick  = grant_q;
    for (int i = 1; i <= NREQ; i++) begin
      logic [GW-1:0] cand;
      cand = GW'((int'(ptr_q) + i) % NREQ);
      if (!found && i_req_request[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    op_d     = op_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    op3_d    = op3_q;
    result_d = result_q;
`ifdef CPU_FPU_ARB_TIMEOUT_EN
    wait_d    = wait_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef CPU_FPU_ARB_TIMEOUT_EN
        wait_d = '0;
`endif
        if (found) begin
          state_d = ISSUE;
          grant_d = pick;
          ptr_d   = pick;
          for (int k = 0; k < NREQ; k++) begin
            if (GW'(k) == pick) begin
              op_d  = i_req_op[5*k +: 5];
              op1_d = i_req_op1[32*k +: 32];
              op2_d = i_req_op2[32*k +: 32];
              op3_d = i_req_op3[32*k +: 32];
            end
          end
        end
      end
      ISSUE: begin
        if (i_fpu_ready) begin
          result_d = i_fpu_result;
          state_d  = DONE;
        end
`ifdef CPU_FPU_ARB_TIMEOUT_EN
        else if (wait_q == CW'(TIMEOUT)) begin
          result_d  = 32'h7fc0_0000;
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      ptr_q    <= GW'(NREQ - 1);
      op_q     <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      op3_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      op_q     <= op_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      op3_q    <= op3_d;
      result_q <= result_d;
    end
  end

`ifdef CPU_FPU_ARB_TIMEOUT_EN
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end
  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

  // Ready pulse is gated by the live request so a withdrawn requester sees nothing.
  always_comb begin
    o_req_ready = '0;
    if (state_q == DONE) o_req_ready[grant_q] = i_req_request[grant_q];
  end

  assign o_req_result  = result_q;
  assign o_fpu_request = (state_q == ISSUE);
  assign o_fpu_op      = op_q;
  assign o_fpu_op1     = op1_q;
  assign o_fpu_op2     = op2_q;
  assign o_fpu_op3     = op3_q;
  assign o_busy        = (state_q != IDLE);

endmodule
